// File: rtl/button_press_classifier_pkg.sv
// Shared project definitions for the button press classifier.
package button_press_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } press_state_t;

    localparam int DEFAULT_LONG_CYCLES   = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES = 10_000_000;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into press, short, long, repeat and
// release events using one FSM and a single shared hold counter.
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_clean,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int CNT_W = $clog2(max_of(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    press_state_t     state;
    press_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;
    logic             short_next;
    logic             long_next;
    logic             repeat_next;
    logic             release_next;

    // Next-state and next-output decode; a release always takes priority
    // over a threshold that would have been reached on the same edge.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        release_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_clean) begin
                    state_next = SHORT;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end
            end
            SHORT: begin
                if (!btn_clean) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    short_next   = 1'b1;
                    release_next = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG;
                    cnt_next   = '0;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            LONG: begin
                if (!btn_clean) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_next    = '0;
                    repeat_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; held tracks the next state so it
    // changes on the same edge as the press and release pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press_pulse   <= press_next;
            short_pulse   <= short_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            release_pulse <= release_next;
            held          <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier using a run-length model.
module tb_button_press_classifier;

    localparam int LONG_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;

    logic clk;
    logic rst_n;
    logic btn_clean;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic release_pulse;
    logic held;

    int check_count;
    int pass_count;
    int fail_count;

    // Reference model: number of consecutive high samples of the current press.
    int run_len;
    logic exp_press, exp_short, exp_long, exp_repeat, exp_release, exp_held;

    bit in_random;
    int obs_press_cnt, obs_release_cnt, obs_short_cnt, obs_long_cnt;

    button_press_classifier #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_clean    (btn_clean),
        .press_pulse  (press_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic observed, input logic expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected outputs after an edge, derived from how long the button has been held.
    task automatic model_edge(input logic r, input logic b);
        exp_press   = 1'b0;
        exp_short   = 1'b0;
        exp_long    = 1'b0;
        exp_repeat  = 1'b0;
        exp_release = 1'b0;
        exp_held    = 1'b0;
        if (!r) begin
            run_len = 0;
        end else if (b) begin
            run_len++;
            exp_press  = (run_len == 1);
            exp_long   = (run_len == LONG_CYCLES + 1);
            exp_repeat = (run_len > LONG_CYCLES + 1) &&
                         (((run_len - LONG_CYCLES - 1) % REPEAT_CYCLES) == 0);
            exp_held   = 1'b1;
        end else begin
            exp_release = (run_len > 0);
            exp_short   = (run_len > 0) && (run_len <= LONG_CYCLES);
            run_len     = 0;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic b);
        int busy;
        @(negedge clk);
        rst_n     = r;
        btn_clean = b;
        @(posedge clk);
        #1;
        model_edge(r, b);
        check_output("press_pulse",   press_pulse,   exp_press);
        check_output("short_pulse",   short_pulse,   exp_short);
        check_output("long_pulse",    long_pulse,    exp_long);
        check_output("repeat_pulse",  repeat_pulse,  exp_repeat);
        check_output("release_pulse", release_pulse, exp_release);
        check_output("held",          held,          exp_held);
        busy = int'(press_pulse) + int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse);
        check_output("exclusive", ((busy <= 1) && (!release_pulse || (busy == int'(short_pulse)))), 1'b1);
        if (in_random) begin
            obs_press_cnt   += int'(press_pulse);
            obs_release_cnt += int'(release_pulse);
            obs_short_cnt   += int'(short_pulse);
            obs_long_cnt    += int'(long_pulse);
        end
    endtask

    task automatic hold_press(input int high_cycles, input int low_cycles);
        for (int i = 0; i < high_cycles; i++) apply_stimulus(1'b1, 1'b1);
        for (int i = 0; i < low_cycles; i++)  apply_stimulus(1'b1, 1'b0);
    endtask

    initial begin
        check_count     = 0;
        pass_count      = 0;
        fail_count      = 0;
        run_len         = 0;
        in_random       = 1'b0;
        obs_press_cnt   = 0;
        obs_release_cnt = 0;
        obs_short_cnt   = 0;
        obs_long_cnt    = 0;
        rst_n           = 1'b0;
        btn_clean       = 1'b0;

        $display("[TB] reset");
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0);

        $display("[TB] short press of 3 cycles");
        hold_press(3, 3);

        $display("[TB] long press with auto-repeat");
        hold_press(21, 3);

        $display("[TB] release on the long threshold edge");
        hold_press(LONG_CYCLES, 3);

        $display("[TB] one cycle past the long threshold");
        hold_press(LONG_CYCLES + 1, 3);

        $display("[TB] reset while long-held");
        hold_press(12, 0);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        hold_press(3, 3);

        $display("[TB] one-cycle glitch");
        hold_press(1, 1);
        hold_press(1, 3);

        $display("[TB] random presses");
        in_random = 1'b1;
        for (int p = 0; p < 200; p++) begin
            hold_press(int'($urandom_range(40, 1)), int'($urandom_range(4, 1)));
        end
        in_random = 1'b0;
        check_output("random_press_count",   (obs_press_cnt == 200),   1'b1);
        check_output("random_release_count", (obs_release_cnt == 200), 1'b1);
        check_output("random_short_long_sum", ((obs_short_cnt + obs_long_cnt) == 200), 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
